c_rotator: RTL and testbench

Pipelined complex rotator for the inverse 8-point FFT datapath: multiplies a complex sample by e^{+jπk/4}, k ∈ {0,1,2,3}, the conjugate twiddles of the forward butterfly. The 1/√2 factor is a fixed shift-add constant, so the block needs no hardware multiplier. It sits between the inverse-FFT butterfly stages and carries a valid/ready handshake with backpressure. Latency is fixed at 3 cycles.

---
 rtl/c_rotator_pkg.sv | 21 ++
 rtl/c_scale707.sv | 48 ++++
 rtl/c_rotator.sv | 151 +++++++++++++++
 tb/tb_c_rotator.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/c_rotator_pkg.sv
// Shared constants for the inverse-FFT complex rotator: shift-add taps of the
// 1/sqrt(2) constant (181/256), rotation codes and pipeline depth.
package c_rotator_pkg;

  localparam int SH_A = 1;
  localparam int SH_B = 3;
  localparam int SH_C = 4;
  localparam int SH_D = 6;
  localparam int SH_E = 8;

  localparam int NUM_STAGES = 3;

  // Rotation by e^{+j*pi*k/4}
  typedef enum logic [1:0] {
    K_0    = 2'd0,
    K_PI4  = 2'd1,
    K_PI2  = 2'd2,
    K_3PI4 = 2'd3
  } rot_k_e;

endpackage

// File: rtl/c_scale707.sv
// Two-stage shift-add multiply by 181/256: floored partial sums are registered,
// the final three-way add is combinational and lands in the consumer's stage.
module c_scale707
  import c_rotator_pkg::*;
#(
  parameter int WO = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [WO-1:0] x,
  output logic [WO-1:0] y
);

  logic signed [WO-1:0] xs;
  logic signed [WO-1:0] p1_d, p1_q;
  logic signed [WO-1:0] p2_d, p2_q;
  logic signed [WO-1:0] p3_d, p3_q;

  assign xs = $signed(x);

  // Each term floors on its own, so the sum differs from floor(181*x/256).
  always_comb begin
    p1_d = p1_q;
    p2_d = p2_q;
    p3_d = p3_q;
    if (en) begin
      p1_d = (xs >>> SH_A) + (xs >>> SH_B);
      p2_d = (xs >>> SH_C) + (xs >>> SH_D);
      p3_d = xs >>> SH_E;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p1_q <= '0;
      p2_q <= '0;
      p3_q <= '0;
    end else begin
      p1_q <= p1_d;
      p2_q <= p2_d;
      p3_q <= p3_d;
    end
  end

  assign y = p1_q + p2_q + p3_q;

endmodule

// File: rtl/c_rotator.sv
// Pipelined multiplier-free rotator by e^{+j*pi*k/4} for the inverse 8-point FFT,
// three register stages with a single global enable for valid/ready backpressure.
module c_rotator
  import c_rotator_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = 2 ** N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  input  logic [1:0]   in_k,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out_re,
  output logic [W:0]   out_im
);

  logic         en;
  logic [W:0]   in_re_x, in_im_x;

  logic         v1_d, v1_q, v2_d, v2_q, ov_d, ov_q;
  logic [W-1:0] re1_d, re1_q, im1_d, im1_q;
  logic [W-1:0] re2_d, re2_q, im2_d, im2_q;
  logic [W:0]   dif1_d, dif1_q, sum1_d, sum1_q;
  rot_k_e       k1_d, k1_q, k2_d, k2_q;
  logic [W:0]   ore_d, ore_q, oim_d, oim_q;
  logic [W:0]   sc_dif, sc_sum, re2_x, im2_x;

  // The whole pipe stalls only when a valid output is being refused.
  assign en       = out_ready | ~ov_q;
  assign in_ready = en | ~rst;

  assign in_re_x = {in_re[W-1], in_re};
  assign in_im_x = {in_im[W-1], in_im};
  assign re2_x   = {re2_q[W-1], re2_q};
  assign im2_x   = {im2_q[W-1], im2_q};

  always_comb begin
    v1_d   = v1_q;
    re1_d  = re1_q;
    im1_d  = im1_q;
    dif1_d = dif1_q;
    sum1_d = sum1_q;
    k1_d   = k1_q;
    v2_d   = v2_q;
    re2_d  = re2_q;
    im2_d  = im2_q;
    k2_d   = k2_q;
    if (en) begin
      v1_d   = in_valid;
      re1_d  = in_re;
      im1_d  = in_im;
      dif1_d = in_re_x - in_im_x;
      sum1_d = in_re_x + in_im_x;
      k1_d   = rot_k_e'(in_k);
      v2_d   = v1_q;
      re2_d  = re1_q;
      im2_d  = im1_q;
      k2_d   = k1_q;
    end
  end

  c_scale707 #(.WO(W + 1)) u_scale_dif (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .x   (dif1_q),
    .y   (sc_dif)
  );

  c_scale707 #(.WO(W + 1)) u_scale_sum (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .x   (sum1_q),
    .y   (sc_sum)
  );

  // One extra bit of headroom keeps every negation and the scaled extremes exact.
  always_comb begin
    ov_d  = ov_q;
    ore_d = ore_q;
    oim_d = oim_q;
    if (en) begin
      ov_d = v2_q;
      case (k2_q)
        K_0: begin
          ore_d = re2_x;
          oim_d = im2_x;
        end
        K_PI4: begin
          ore_d = sc_dif;
          oim_d = sc_sum;
        end
        K_PI2: begin
          ore_d = -im2_x;
          oim_d = re2_x;
        end
        K_3PI4: begin
          ore_d = -sc_sum;
          oim_d = sc_dif;
        end
        default: begin
          ore_d = re2_x;
          oim_d = im2_x;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q   <= 1'b0;
      re1_q  <= '0;
      im1_q  <= '0;
      dif1_q <= '0;
      sum1_q <= '0;
      k1_q   <= K_0;
      v2_q   <= 1'b0;
      re2_q  <= '0;
      im2_q  <= '0;
      k2_q   <= K_0;
      ov_q   <= 1'b0;
      ore_q  <= '0;
      oim_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      re1_q  <= re1_d;
      im1_q  <= im1_d;
      dif1_q <= dif1_d;
      sum1_q <= sum1_d;
      k1_q   <= k1_d;
      v2_q   <= v2_d;
      re2_q  <= re2_d;
      im2_q  <= im2_d;
      k2_q   <= k2_d;
      ov_q   <= ov_d;
      ore_q  <= ore_d;
      oim_q  <= oim_d;
    end
  end

  assign out_valid = ov_q;
  assign out_re    = ore_q;
  assign out_im    = oim_q;

endmodule

// File: tb/tb_c_rotator.sv
// Scoreboard bench for c_rotator: accepted samples are modelled with exact
// integer arithmetic and queued; a negedge monitor pops and compares outputs.
module tb_c_rotator;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_re = '0;
  logic [W-1:0] in_im = '0;
  logic [1:0]   in_k = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W:0]   out_re, out_im;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int or_mode = 0;
  bit lat_check = 1'b0;

  typedef struct {
    int re;
    int im;
    int acc;
    bit lat;
  } exp_t;

  exp_t exp_q[$];

  bit         prev_stall = 1'b0;
  logic [W:0] prev_re = '0;
  logic [W:0] prev_im = '0;

  c_rotator #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_k      (in_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Floor division by a power of two, written as plain integer arithmetic.
  function automatic int floor_div_pow2(input int x, input int s);
    int d;
    int q;
    d = 1 << s;
    q = x / d;
    if ((x % d) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  function automatic int ref_scale(input int x);
    int sh[5] = '{1, 3, 4, 6, 8};
    int acc;
    acc = 0;
    foreach (sh[i]) acc += floor_div_pow2(x, sh[i]);
    return acc;
  endfunction

  function automatic void ref_rotate(input int re, input int im, input int k,
                                     output int ore, output int oim);
    int d;
    int s;
    d = re - im;
    s = re + im;
    case (k)
      0: begin ore = re;             oim = im;           end
      1: begin ore = ref_scale(d);   oim = ref_scale(s); end
      2: begin ore = -im;            oim = re;           end
      default: begin ore = -ref_scale(s); oim = ref_scale(d); end
    endcase
  endfunction

  task automatic check_output(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0d required %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Stimulus-side tap: every handshake pushes the modelled response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      ref_rotate($signed(in_re), $signed(in_im), int'(in_k), e.re, e.im);
      e.acc = cyc;
      e.lat = lat_check;
      exp_q.push_back(e);
    end
  end

  // Monitor: compares on every output transfer, independent of the driver.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      check_output("in_ready_en", int'(in_ready), int'(out_ready || !out_valid));
      if (prev_stall) begin
        check_output("hold_valid", int'(out_valid), 1);
        check_output("hold_re", $signed(out_re), $signed(prev_re));
        check_output("hold_im", $signed(out_im), $signed(prev_im));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output: got re=%0d im=%0d required none (cycle %0d)",
                   $signed(out_re), $signed(out_im), cyc);
        end else begin
          e = exp_q.pop_front();
          check_output("out_re", $signed(out_re), e.re);
          check_output("out_im", $signed(out_im), e.im);
          if (e.lat) check_output("latency", cyc - e.acc, 3);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_re    = out_re;
      prev_im    = out_im;
    end
  end

  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((cyc % 3) == 0);
      default: out_ready = 1'($urandom_range(1));
    endcase
  end

  // Present one sample and hold it until the handshake edge has passed.
  task automatic apply_stimulus(input int re, input int im, input int k);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_re    = W'(re);
    in_im    = W'(im);
    in_k     = 2'(k);
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 required 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_output("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b1;
    in_re    = 16'd1234;
    in_im    = 16'd4321;
    in_k     = 2'd1;
    #1;
    check_output("rst_in_ready_pre", int'(in_ready), 1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_output("rst_out_valid", int'(out_valid), 0);
      check_output("rst_out_re", int'(out_re), 0);
      check_output("rst_out_im", int'(out_im), 0);
      check_output("rst_in_ready", int'(in_ready), 1);
    end
    rst = 1'b1;
    idle(6);
    check_output("post_rst_quiet", int'(out_valid), 0);

    lat_check = 1'b1;
    apply_stimulus(1000, 0, 1);
    apply_stimulus(1000, 0, 3);
    apply_stimulus(0, 1000, 1);
    apply_stimulus(100, 200, 2);
    apply_stimulus(-32768, 32767, 0);
    apply_stimulus(-32768, -32768, 3);
    apply_stimulus(32767, 32767, 1);
    apply_stimulus(32767, -32768, 3);
    drain();

    lat_check = 1'b0;
    or_mode = 1;
    for (int i = 0; i < 8; i++)
      apply_stimulus(int'($urandom), int'($urandom), (i * 3) % 4);
    drain();
    or_mode = 0;
    idle(2);

    or_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      else apply_stimulus(int'($urandom), int'($urandom), int'($urandom_range(3)));
    end
    drain();
    or_mode = 0;
    idle(2);

    lat_check = 1'b1;
    apply_stimulus(500, -700, 1);
    apply_stimulus(-1, 1, 3);
    apply_stimulus(12345, -54, 2);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(6);
    check_output("flush_quiet", int'(out_valid), 0);
    check_output("flush_queue", exp_q.size(), 0);
    apply_stimulus(-20000, 7777, 3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
